// File: rtl/score_board_multi.sv
// ---------------------------------------------------------------------------
// score_board_multi
//
// Multi-player BCD scoreboard with a time-multiplexed seven-segment display.
// Each player has a saturating BCD up/down counter. The first player whose
// score lands exactly on WIN_SCORE is latched as the winner. While a winner
// is latched, score pulses are ignored until newGame clears the board. A free
// running refresh counter walks one lit digit across every player's digits.
//
// Parameters
//   NUM_PLAYERS  number of independent score channels (2..4)
//   DIGITS       BCD digits per player (1..3), max score 10^DIGITS-1
//   WIN_SCORE    score that ends a game (1..10^DIGITS-1)
//   REFRESH_DIV  clk cycles each display digit stays lit (>= 2)
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous, active-low reset
//   newGame    one-cycle pulse clearing scores and winner
//   scoreUp    per-player one-cycle increment pulses
//   scoreDown  per-player one-cycle decrement pulses
//   score_bcd  registered BCD scores, player p at bit p*DIGITS*4, LS digit low
//   winner     registered one-hot winning player, zero while no winner
//   game_over  OR of winner
//   seg        active-low segments a..g (seg[0] = a)
//   dp         active-low decimal point, marks digit 0 of the winner
//   an         active-low anodes, an[p*DIGITS+d] is digit d of player p
// ---------------------------------------------------------------------------
module score_board_multi #(
  parameter int NUM_PLAYERS = 2,
  parameter int DIGITS      = 2,
  parameter int WIN_SCORE   = 10,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            newGame,
  input  logic [NUM_PLAYERS-1:0]          scoreUp,
  input  logic [NUM_PLAYERS-1:0]          scoreDown,
  output logic [NUM_PLAYERS*DIGITS*4-1:0] score_bcd,
  output logic [NUM_PLAYERS-1:0]          winner,
  output logic                            game_over,
  output logic [6:0]                      seg,
  output logic                            dp,
  output logic [NUM_PLAYERS*DIGITS-1:0]   an
);

  localparam int PW      = DIGITS * 4;
  localparam int NUM_DIG = NUM_PLAYERS * DIGITS;
  localparam int SW      = $clog2(NUM_DIG);
  localparam int RW      = $clog2(REFRESH_DIV);

  // Converts a plain integer into a packed BCD word of DIGITS digits.
  function automatic logic [PW-1:0] intToBcd(input int value);
    logic [PW-1:0] r;
    int            rem;
    r   = '0;
    rem = value;
    for (int d = 0; d < DIGITS; d++) begin
      r[d*4 +: 4] = 4'(rem % 10);
      rem         = rem / 10;
    end
    return r;
  endfunction

  localparam logic [PW-1:0] WIN_BCD = intToBcd(WIN_SCORE);
  localparam logic [PW-1:0] MAX_BCD = {DIGITS{4'd9}};

  // BCD +1 with decimal carry; the caller keeps MAX_BCD from wrapping.
  function automatic logic [PW-1:0] bcdInc(input logic [PW-1:0] v);
    logic [PW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (v[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // BCD -1 with decimal borrow; the caller keeps zero from wrapping.
  function automatic logic [PW-1:0] bcdDec(input logic [PW-1:0] v);
    logic [PW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (borrow) begin
        if (v[d*4 +: 4] == 4'd0) begin
          r[d*4 +: 4] = 4'd9;
        end else begin
          r[d*4 +: 4] = v[d*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Hex to active-low seven-segment pattern, bit order g..a.
  function automatic logic [6:0] sevenSeg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Game state
  logic [NUM_PLAYERS*PW-1:0] score_q, score_d;
  logic [NUM_PLAYERS-1:0]    winner_q, winner_d;
  logic                      gameOver;

  // Display scan state and registered display outputs
  logic [RW-1:0]      refresh_q, refresh_d;
  logic [SW-1:0]      scan_q, scan_d;
  logic [NUM_DIG-1:0] an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic [3:0]         selDigit;

  assign gameOver = |winner_q;

  // Score update: newGame wins over everything; otherwise each player moves
  // independently unless a winner is already latched. Opposing pulses cancel
  // and the counters stop at both ends. The winner check looks at the updated
  // scores so the win lands on the same edge, lowest index first.
  always_comb begin
    logic [PW-1:0] cur;
    logic          found;
    score_d  = score_q;
    winner_d = winner_q;
    cur      = '0;
    found    = 1'b0;
    if (newGame) begin
      score_d  = '0;
      winner_d = '0;
    end else if (!gameOver) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        cur = score_q[p*PW +: PW];
        if (scoreUp[p] && !scoreDown[p] && (cur != MAX_BCD)) begin
          score_d[p*PW +: PW] = bcdInc(cur);
        end else if (scoreDown[p] && !scoreUp[p] && (cur != '0)) begin
          score_d[p*PW +: PW] = bcdDec(cur);
        end
      end
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (!found && (score_d[p*PW +: PW] == WIN_BCD)) begin
          winner_d[p] = 1'b1;
          found       = 1'b1;
        end
      end
    end
  end

  // Refresh divider and scan index. The scan index steps once per full
  // refresh period and wraps after the last digit of the last player.
  always_comb begin
    refresh_d = refresh_q + RW'(1);
    scan_d    = scan_q;
    if (refresh_q == RW'(REFRESH_DIV - 1)) begin
      refresh_d = '0;
      if (scan_q == SW'(NUM_DIG - 1)) begin
        scan_d = '0;
      end else begin
        scan_d = scan_q + SW'(1);
      end
    end
  end

  // Display decode for the currently scanned digit. Player p digit d sits at
  // flat digit index p*DIGITS+d in both the score vector and the anodes, so
  // one index selects both. The decimal point marks the winner's digit 0.
  always_comb begin
    selDigit = 4'd0;
    an_d     = '1;
    dp_d     = 1'b1;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (scan_q == SW'(i)) begin
        selDigit = score_q[i*4 +: 4];
        an_d[i]  = 1'b0;
      end
    end
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (winner_q[p] && (scan_q == SW'(p * DIGITS))) begin
        dp_d = 1'b0;
      end
    end
    seg_d = sevenSeg(selDigit);
  end

  // All state registers share the asynchronous active-low reset, which blanks
  // the display and discards every score and the winner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      score_q   <= '0;
      winner_q  <= '0;
      refresh_q <= '0;
      scan_q    <= '0;
      an_q      <= '1;
      seg_q     <= '1;
      dp_q      <= 1'b1;
    end else begin
      score_q   <= score_d;
      winner_q  <= winner_d;
      refresh_q <= refresh_d;
      scan_q    <= scan_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign score_bcd = score_q;
  assign winner    = winner_q;
  assign game_over = gameOver;
  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;

endmodule

// File: tb/tb_score_board_multi.sv
// ---------------------------------------------------------------------------
// tb_score_board_multi
//
// Scoreboard bench for score_board_multi with two players, two digits,
// WIN_SCORE=10 and REFRESH_DIV=4. Every driven cycle advances an integer
// reference model and queues the outputs expected after that edge; a monitor
// pops and compares after each rising edge. Directed scenarios are followed by
// a randomized run with occasional newGame pulses and a mid-run reset.
// ---------------------------------------------------------------------------
module tb_score_board_multi;

  localparam int NP   = 2;
  localparam int DG   = 2;
  localparam int WIN  = 10;
  localparam int RDIV = 4;
  localparam int MAXS = 99;

  logic          clk;
  logic          reset;
  logic          newGame;
  logic [NP-1:0] scoreUp;
  logic [NP-1:0] scoreDown;
  logic [15:0]   score_bcd;
  logic [NP-1:0] winner;
  logic          game_over;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;

  score_board_multi #(
    .NUM_PLAYERS (NP),
    .DIGITS      (DG),
    .WIN_SCORE   (WIN),
    .REFRESH_DIV (RDIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .newGame   (newGame),
    .scoreUp   (scoreUp),
    .scoreDown (scoreDown),
    .score_bcd (score_bcd),
    .winner    (winner),
    .game_over (game_over),
    .seg       (seg),
    .dp        (dp),
    .an        (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] score;
    logic [1:0]  win;
    logic        go;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } exp_t;

  exp_t expQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;

  // Reference model: plain integer scores, winner index (-1 = none), and the
  // scan position as a cycle counter plus digit index.
  int mScore[NP];
  int mWinner;
  int mRef;
  int mScan;

  // Active-low seven-segment patterns for decimal digits, bit order g..a.
  function automatic logic [6:0] segOf(input int v);
    case (v)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int q = 0; q < NP; q++) mScore[q] = 0;
    mWinner = -1;
    mRef    = 0;
    mScan   = 0;
  endtask

  // Advances the model by one clock edge with the given inputs and queues the
  // outputs expected right after that edge. The display shows what was
  // scanned and stored before the edge.
  task automatic modelStep(input logic [NP-1:0] up, input logic [NP-1:0] dn, input logic ng);
    exp_t       e;
    int         p;
    int         d;
    int         digit;
    logic [3:0] a;
    p     = mScan / DG;
    d     = mScan % DG;
    digit = (d == 0) ? (mScore[p] % 10) : ((mScore[p] / 10) % 10);
    a        = 4'hF;
    a[mScan] = 1'b0;
    e.an  = a;
    e.seg = segOf(digit);
    e.dp  = (mWinner == p && d == 0) ? 1'b0 : 1'b1;

    if (ng) begin
      for (int q = 0; q < NP; q++) mScore[q] = 0;
      mWinner = -1;
    end else if (mWinner < 0) begin
      for (int q = 0; q < NP; q++) begin
        if (up[q] && !dn[q] && mScore[q] < MAXS) mScore[q] = mScore[q] + 1;
        else if (dn[q] && !up[q] && mScore[q] > 0) mScore[q] = mScore[q] - 1;
      end
      for (int q = 0; q < NP; q++) begin
        if (mWinner < 0 && mScore[q] == WIN) mWinner = q;
      end
    end

    e.score = '0;
    for (int q = 0; q < NP; q++) begin
      e.score[q*8 +: 8] = 8'(((mScore[q] / 10) % 10) * 16 + (mScore[q] % 10));
    end
    e.win = (mWinner < 0) ? 2'b00 : 2'(1 << mWinner);
    e.go  = (mWinner >= 0);

    if (mRef == RDIV - 1) begin
      mRef  = 0;
      mScan = (mScan + 1) % (NP * DG);
    end else begin
      mRef = mRef + 1;
    end
    expQ.push_back(e);
  endtask

  // One driven cycle: inputs change on the falling edge, the model predicts
  // the following rising edge.
  task automatic applyStimulus(input logic [NP-1:0] up, input logic [NP-1:0] dn, input logic ng);
    @(negedge clk);
    scoreUp   = up;
    scoreDown = dn;
    newGame   = ng;
    modelStep(up, dn, ng);
  endtask

  // Waits for the edge of the last applied stimulus and lets it settle.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".score"}, 32'(score_bcd), 'h0);
    checkOutput({tag, ".winner"}, 32'(winner), 'h0);
    checkOutput({tag, ".gameOver"}, 32'(game_over), 'h0);
    checkOutput({tag, ".an"}, 32'(an), 'hF);
    checkOutput({tag, ".seg"}, 32'(seg), 'h7F);
    checkOutput({tag, ".dp"}, 32'(dp), 'h1);
  endtask

  // Asserts reset between edges, checks the outputs clear without a clock
  // edge and stay cleared while held, then releases it and predicts the
  // first edge after release.
  task automatic doReset(input string tag);
    @(negedge clk);
    reset     = 1'b0;
    scoreUp   = '0;
    scoreDown = '0;
    newGame   = 1'b0;
    #1;
    checkResetValues({tag, ".async"});
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkResetValues({tag, ".held"});
    @(negedge clk);
    reset = 1'b1;
    modelStep('0, '0, 1'b0);
  endtask

  // Monitor: compares every queued prediction just after its edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("mon.score", 32'(score_bcd), 32'(e.score));
        checkOutput("mon.winner", 32'(winner), 32'(e.win));
        checkOutput("mon.gameOver", 32'(game_over), 32'(e.go));
        checkOutput("mon.an", 32'(an), 32'(e.an));
        checkOutput("mon.seg", 32'(seg), 32'(e.seg));
        checkOutput("mon.dp", 32'(dp), 32'(e.dp));
      end
    end
  end

  initial begin
    logic [NP-1:0] up;
    logic [NP-1:0] dn;
    logic          ng;
    reset     = 1'b0;
    newGame   = 1'b0;
    scoreUp   = '0;
    scoreDown = '0;
    modelReset();

    doReset("por");

    // Player 0 climbs to the winning score.
    repeat (9) applyStimulus(2'b01, 2'b00, 1'b0);
    settle();
    checkOutput("p0AtNine", 32'(score_bcd[7:0]), 'h09);
    applyStimulus(2'b01, 2'b00, 1'b0);
    settle();
    checkOutput("p0AtTen", 32'(score_bcd[7:0]), 'h10);
    checkOutput("p0Wins", 32'(winner), 'h1);
    checkOutput("gameOverSet", 32'(game_over), 'h1);
    applyStimulus(2'b10, 2'b01, 1'b0);
    settle();
    checkOutput("frozenAfterWin", 32'(score_bcd), 'h0010);

    // newGame beats a simultaneous score pulse, then play resumes.
    applyStimulus(2'b01, 2'b00, 1'b1);
    settle();
    checkOutput("newGameClears", 32'(score_bcd), 'h0);
    checkOutput("newGameWinner", 32'(winner), 'h0);
    applyStimulus(2'b01, 2'b00, 1'b0);
    settle();
    checkOutput("countAfterNewGame", 32'(score_bcd[7:0]), 'h01);

    // Decrement saturation at zero and cancelling pulses.
    applyStimulus(2'b00, 2'b00, 1'b1);
    applyStimulus(2'b00, 2'b10, 1'b0);
    settle();
    checkOutput("p1FloorZero", 32'(score_bcd[15:8]), 'h00);
    repeat (5) applyStimulus(2'b10, 2'b00, 1'b0);
    applyStimulus(2'b10, 2'b10, 1'b0);
    settle();
    checkOutput("p1UpDownCancel", 32'(score_bcd[15:8]), 'h05);
    applyStimulus(2'b00, 2'b10, 1'b0);
    settle();
    checkOutput("p1Decrement", 32'(score_bcd[15:8]), 'h04);

    // Simultaneous win: lowest index takes it.
    applyStimulus(2'b00, 2'b00, 1'b1);
    repeat (9) applyStimulus(2'b11, 2'b00, 1'b0);
    settle();
    checkOutput("bothAtNine", 32'(score_bcd), 'h0909);
    applyStimulus(2'b11, 2'b00, 1'b0);
    settle();
    checkOutput("bothAtTen", 32'(score_bcd), 'h1010);
    checkOutput("tieLowestWins", 32'(winner), 'h1);
    applyStimulus(2'b10, 2'b00, 1'b0);
    settle();
    checkOutput("tieFrozen", 32'(score_bcd), 'h1010);

    // Display scan with P0=10 (winner) and P1=07 over several periods.
    applyStimulus(2'b00, 2'b00, 1'b1);
    repeat (7) applyStimulus(2'b11, 2'b00, 1'b0);
    repeat (3) applyStimulus(2'b01, 2'b00, 1'b0);
    repeat (24) applyStimulus(2'b00, 2'b00, 1'b0);
    settle();
    checkOutput("scanScores", 32'(score_bcd), 'h0710);

    // Reset mid-scan with P0=04.
    applyStimulus(2'b00, 2'b00, 1'b1);
    repeat (4) applyStimulus(2'b01, 2'b00, 1'b0);
    repeat (6) applyStimulus(2'b00, 2'b00, 1'b0);
    doReset("midScan");
    settle();
    checkOutput("restartAn", 32'(an), 'hE);
    checkOutput("restartSeg", 32'(seg), 'h40);
    checkOutput("restartScore", 32'(score_bcd), 'h0);

    // Randomized play.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) doReset("rand");
      ng = ($urandom_range(0, 29) == 0);
      for (int b = 0; b < NP; b++) begin
        up[b] = ($urandom_range(0, 99) < 55);
        dn[b] = ($urandom_range(0, 99) < 25);
      end
      applyStimulus(up, dn, ng);
    end
    repeat (3) applyStimulus(2'b00, 2'b00, 1'b0);

    for (int k = 0; k < 10 && expQ.size() > 0; k++) settle();
    checkOutput("queueDrained", 32'(expQ.size()), 'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
